unified_mem_arbiter: RTL

- Parametrised successor to the core's hard-wired split ROM/RAM ports and fixed stall logic.
- Arbitrates instruction-fetch and load/store requests onto one single-port memory with a configurable fixed latency.
- Generates the per-stage pipeline stall vector for a configurable pipeline depth, merging in execute-stage stall requests.
- Sits between the pipeline (pc/if and mem stages) and the memory; supersedes the ctrl-style stall generator.

---
 rtl/unified_mem_arbiter_pkg.sv | 28 ++
 rtl/unified_mem_arbiter_if.sv | 43 ++++
 rtl/unified_mem_arbiter_stall_vec_gen.sv | 35 +++
 rtl/unified_mem_arbiter.sv | 138 +++++++++++++
 4 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : unified_mem_arbiter_pkg
// Brief    : Stage indices, FSM encoding and latency limits for the arbiter.
// Revision : 1.0
// ============================================================================
package unified_mem_arbiter_pkg;

  localparam int c_STG_PC  = 0;
  localparam int c_STG_IF  = 1;
  localparam int c_STG_ID  = 2;
  localparam int c_STG_EX  = 3;
  localparam int c_STG_MEM = 4;
  localparam int c_STG_WB  = 5;

  localparam int c_CNT_W       = 4;
  localparam int c_MEM_LAT_MIN = 1;
  localparam int c_MEM_LAT_MAX = (1 << c_CNT_W) - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DBUSY = 2'd1,
    ST_FBUSY = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage : unified_mem_arbiter_pkg
`default_nettype wire

// File: rtl/unified_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : unified_mem_arbiter_if
// Brief    : Pipeline request/response, memory bus and stall vector bundle.
// Revision : 1.0
// ============================================================================
interface unified_mem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int STAGES = 6
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  logic              flush;
  logic              stallreq_ex;
  logic              mem_ce;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [STAGES-1:0] stall;

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, flush, stallreq_ex, mem_rdata,
    input  if_rdata, if_valid, d_rdata, d_valid, mem_ce, mem_we, mem_addr, mem_wdata, stall
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, flush, stallreq_ex, mem_rdata,
    output if_rdata, if_valid, d_rdata, d_valid, mem_ce, mem_we, mem_addr, mem_wdata, stall
  );

endinterface : unified_mem_arbiter_if
`default_nettype wire

// File: rtl/unified_mem_arbiter_stall_vec_gen.sv
`default_nettype none
// ============================================================================
// Module   : unified_mem_arbiter_stall_vec_gen
// Brief    : Priority encoder from stall sources to the per-stage stall vector.
// Revision : 1.0
// ============================================================================
module unified_mem_arbiter_stall_vec_gen
  import unified_mem_arbiter_pkg::*;
#(
  parameter int STAGES    = 6,
  parameter int EX_STAGE  = 3,
  parameter int MEM_STAGE = 4
) (
  input  wire logic              i_stall_d,
  input  wire logic              i_stall_ex,
  input  wire logic              i_stall_f,
  output logic      [STAGES-1:0] o_stall
);

  // Stages above the frozen range stay clear so a bubble drains downstream.
  always_comb begin
    o_stall = '0;
    for (int i = 0; i < STAGES; i++) begin
      if (i_stall_d) begin
        o_stall[i] = (i <= MEM_STAGE);
      end else if (i_stall_ex) begin
        o_stall[i] = (i <= EX_STAGE);
      end else if (i_stall_f) begin
        o_stall[i] = (i <= c_STG_IF);
      end
    end
  end

endmodule : unified_mem_arbiter_stall_vec_gen
`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : unified_mem_arbiter
// Brief    : Fetch/load-store arbiter onto one fixed-latency memory + stalls.
// Revision : 1.0
// ============================================================================
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int STAGES    = 6,
  parameter int EX_STAGE  = 3,
  parameter int MEM_STAGE = 4,
  parameter int MEM_LAT   = 2
) (
  input wire logic            clk,
  input wire logic            rst,
  unified_mem_arbiter_if.slave bus
);

  generate
    if (MEM_LAT < c_MEM_LAT_MIN || MEM_LAT > c_MEM_LAT_MAX ||
        !(EX_STAGE < MEM_STAGE && MEM_STAGE < STAGES)) begin : g_bad_params
      $error("unified_mem_arbiter: illegal MEM_LAT or stage ordering");
    end
  endgenerate

  state_t             r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_discard;
  logic               r_mem_ce;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_wdata;
  logic [DATA_W-1:0]  r_if_rdata;
  logic               r_if_valid;
  logic [DATA_W-1:0]  r_d_rdata;
  logic               r_d_valid;
  logic               w_stall_d;
  logic               w_stall_f;
  logic [STAGES-1:0]  w_stall_vec;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_discard   <= 1'b0;
      r_mem_ce    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_if_valid  <= 1'b0;
      r_d_rdata   <= '0;
      r_d_valid   <= 1'b0;
    end else begin
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.d_req) begin
            r_mem_ce    <= 1'b1;
            r_mem_we    <= bus.d_we;
            r_mem_addr  <= bus.d_addr;
            r_mem_wdata <= bus.d_wdata;
            r_cnt       <= c_CNT_W'(MEM_LAT);
            r_state     <= ST_DBUSY;
          end else if (bus.if_req && !bus.flush) begin
            r_mem_ce    <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= bus.if_addr;
            r_cnt       <= c_CNT_W'(MEM_LAT);
            r_discard   <= 1'b0;
            r_state     <= ST_FBUSY;
          end
        end
        ST_DBUSY: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == c_CNT_W'(1)) begin
            r_mem_ce  <= 1'b0;
            r_mem_we  <= 1'b0;
            r_d_rdata <= bus.mem_rdata;
            r_d_valid <= 1'b1;
            r_state   <= ST_DONE;
          end
        end
        ST_FBUSY: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == c_CNT_W'(1)) begin
            r_mem_ce  <= 1'b0;
            r_mem_we  <= 1'b0;
            r_discard <= 1'b0;
            // A redirected fetch finishes on the bus but never reaches the pipeline.
            if (r_discard || bus.flush) begin
              r_state <= ST_IDLE;
            end else begin
              r_if_rdata <= bus.mem_rdata;
              r_if_valid <= 1'b1;
              r_state    <= ST_DONE;
            end
          end else if (bus.flush) begin
            r_discard <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign w_stall_d = bus.d_req & ~r_d_valid;
  assign w_stall_f = bus.if_req & ~r_if_valid;

  unified_mem_arbiter_stall_vec_gen #(
    .STAGES    (STAGES),
    .EX_STAGE  (EX_STAGE),
    .MEM_STAGE (MEM_STAGE)
  ) u_stall_vec_gen (
    .i_stall_d  (w_stall_d),
    .i_stall_ex (bus.stallreq_ex),
    .i_stall_f  (w_stall_f),
    .o_stall    (w_stall_vec)
  );

  assign bus.stall     = rst ? w_stall_vec : '0;
  assign bus.mem_ce    = r_mem_ce;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.if_valid  = r_if_valid;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.d_valid   = r_d_valid;

endmodule : unified_mem_arbiter
`default_nettype wire
